// File: rtl/tmr_fault_monitor.sv
// TMR fault monitor: flags replicas that disagree with the voted word, keeps saturating
// per-replica error counts, and requests a scrub of any lane that stays wrong THRESH samples.
module tmr_fault_monitor #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned THRESH = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic [WIDTH-1:0] data_3,
    input  logic [WIDTH-1:0] voted_data,
    input  logic             err_clr,
    output logic [2:0]       mismatch,
    output logic             multi_err,
    output logic [CNT_W-1:0] err_cnt_1,
    output logic [CNT_W-1:0] err_cnt_2,
    output logic [CNT_W-1:0] err_cnt_3,
    output logic [2:0]       fault,
    output logic             scrub_valid,
    output logic [1:0]       scrub_sel,
    output logic [WIDTH-1:0] scrub_data,
    input  logic             scrub_ready
);

    typedef enum logic [1:0] {
        S_OK,
        S_SUSPECT,
        S_FAULTY,
        S_SCRUB
    } lane_state_e;

    localparam logic [3:0] LP_THRESH = 4'(THRESH);

    lane_state_e      r_state     [3];
    lane_state_e      w_state_nxt [3];
    logic [3:0]       r_run       [3];
    logic [3:0]       w_run_nxt   [3];
    logic [WIDTH-1:0] r_trig      [3];
    logic [CNT_W-1:0] r_cnt       [3];
    logic [WIDTH-1:0] w_data      [3];
    logic [2:0]       w_mis;
    logic             w_multi;
    logic [2:0]       w_grant;
    logic [1:0]       w_grant_sel;
    logic [WIDTH-1:0] w_grant_data;
    logic             w_hs;

    always_comb begin
        w_data[0] = data_1;
        w_data[1] = data_2;
        w_data[2] = data_3;
        w_mis     = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            w_mis[i] = |(w_data[i] ^ voted_data);
        end
        w_multi = (w_mis[0] & w_mis[1]) | (w_mis[0] & w_mis[2]) | (w_mis[1] & w_mis[2]);
    end

    assign w_hs = scrub_valid & scrub_ready;

    // Fixed-priority arbiter; only looks for a new lane while the port is idle.
    always_comb begin
        logic v_found;
        v_found      = 1'b0;
        w_grant      = '0;
        w_grant_sel  = '0;
        w_grant_data = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!scrub_valid && !v_found && r_state[i] == S_FAULTY) begin
                v_found      = 1'b1;
                w_grant[i]   = 1'b1;
                w_grant_sel  = 2'(i + 1);
                w_grant_data = r_trig[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_state[i] <= S_OK;
                r_run[i]   <= '0;
                r_trig[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_run[i]   <= w_run_nxt[i];
                if (w_state_nxt[i] == S_FAULTY && r_state[i] != S_FAULTY) begin
                    r_trig[i] <= voted_data;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 3; i++) begin
            w_state_nxt[i] = r_state[i];
            w_run_nxt[i]   = r_run[i];
            case (r_state[i])
                S_OK: begin
                    if (in_valid && w_mis[i]) begin
                        w_run_nxt[i]   = 4'd1;
                        w_state_nxt[i] = (LP_THRESH == 4'd1) ? S_FAULTY : S_SUSPECT;
                    end
                end
                S_SUSPECT: begin
                    if (in_valid) begin
                        if (w_mis[i]) begin
                            w_run_nxt[i] = r_run[i] + 4'd1;
                            if (r_run[i] + 4'd1 == LP_THRESH) begin
                                w_state_nxt[i] = S_FAULTY;
                            end
                        end else begin
                            w_run_nxt[i]   = '0;
                            w_state_nxt[i] = S_OK;
                        end
                    end
                end
                S_FAULTY: begin
                    if (w_grant[i]) begin
                        w_state_nxt[i] = S_SCRUB;
                    end
                end
                S_SCRUB: begin
                    if (w_hs && scrub_sel == 2'(i + 1)) begin
                        w_run_nxt[i]   = '0;
                        w_state_nxt[i] = S_OK;
                    end
                end
                default: begin
                    w_run_nxt[i]   = '0;
                    w_state_nxt[i] = S_OK;
                end
            endcase
        end
    end

    always_comb begin
        fault = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            fault[i] = (r_state[i] == S_FAULTY) || (r_state[i] == S_SCRUB);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scrub_valid <= 1'b0;
            scrub_sel   <= '0;
            scrub_data  <= '0;
        end else if (w_hs) begin
            scrub_valid <= 1'b0;
            scrub_sel   <= '0;
            scrub_data  <= '0;
        end else if (|w_grant) begin
            scrub_valid <= 1'b1;
            scrub_sel   <= w_grant_sel;
            scrub_data  <= w_grant_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch  <= '0;
            multi_err <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (in_valid) begin
                mismatch <= w_mis;
            end
            if (in_valid && w_multi) begin
                multi_err <= 1'b1;
            end else if (err_clr) begin
                multi_err <= 1'b0;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                if (err_clr) begin
                    r_cnt[i] <= '0;
                end else if (in_valid && w_mis[i] && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign err_cnt_1 = r_cnt[0];
    assign err_cnt_2 = r_cnt[1];
    assign err_cnt_3 = r_cnt[2];

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Scoreboard bench for tmr_fault_monitor: a default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_tmr_fault_monitor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] data_1, data_2, data_3, voted_data;
    logic       err_clr;
    logic       scrub_ready;

    logic [2:0] mismatch, fault;
    logic       multi_err, scrub_valid;
    logic [7:0] err_cnt_1, err_cnt_2, err_cnt_3;
    logic [1:0] scrub_sel;
    logic [3:0] scrub_data;

    logic [2:0] mismatch2, fault2;
    logic       multi_err2, scrub_valid2;
    logic [1:0] c2_1, c2_2, c2_3;
    logic [1:0] scrub_sel2;
    logic [3:0] scrub_data2;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
    } scrub_t;

    logic [2:0] q_mis[$];
    scrub_t     q_scrub[$];
    int         exp_cnt  [3];
    int         exp_cnt2 [3];
    logic       exp_multi;
    int         n_tests;
    int         n_fail;

    tmr_fault_monitor #(.WIDTH(4), .THRESH(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .data_1(data_1), .data_2(data_2), .data_3(data_3), .voted_data(voted_data),
        .err_clr(err_clr), .mismatch(mismatch), .multi_err(multi_err),
        .err_cnt_1(err_cnt_1), .err_cnt_2(err_cnt_2), .err_cnt_3(err_cnt_3),
        .fault(fault), .scrub_valid(scrub_valid), .scrub_sel(scrub_sel),
        .scrub_data(scrub_data), .scrub_ready(scrub_ready)
    );

    tmr_fault_monitor #(.WIDTH(4), .THRESH(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .data_1(data_1), .data_2(data_2), .data_3(data_3), .voted_data(voted_data),
        .err_clr(err_clr), .mismatch(mismatch2), .multi_err(multi_err2),
        .err_cnt_1(c2_1), .err_cnt_2(c2_2), .err_cnt_3(c2_3),
        .fault(fault2), .scrub_valid(scrub_valid2), .scrub_sel(scrub_sel2),
        .scrub_data(scrub_data2), .scrub_ready(scrub_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One valid sample; expected mismatch pushed and models updated as it is driven.
    task automatic drive_sample(input logic [3:0] d1, input logic [3:0] d2,
                                input logic [3:0] d3, input logic [3:0] v, input logic clr);
        logic [2:0] m;
        int         nm;
        in_valid = 1'b1;
        data_1 = d1; data_2 = d2; data_3 = d3; voted_data = v;
        err_clr = clr;
        m  = {(d3 != v), (d2 != v), (d1 != v)};
        nm = int'(m[0]) + int'(m[1]) + int'(m[2]);
        q_mis.push_back(m);
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                exp_cnt[i]  = 0;
                exp_cnt2[i] = 0;
            end else if (m[i]) begin
                if (exp_cnt[i] < 255) exp_cnt[i]++;
                if (exp_cnt2[i] < 3) exp_cnt2[i]++;
            end
        end
        if (nm >= 2) exp_multi = 1'b1;
        else if (clr) exp_multi = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic do_clear();
        err_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_cnt[i]  = 0;
            exp_cnt2[i] = 0;
        end
        exp_multi = 1'b0;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({mismatch, multi_err, err_cnt_1, err_cnt_2, err_cnt_3, fault, scrub_valid, scrub_sel, scrub_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: mis=%b multi=%b cnt=%0d/%0d/%0d fault=%b sv=%b sel=%0d sd=%h, required all 0",
                     mismatch, multi_err, err_cnt_1, err_cnt_2, err_cnt_3, fault, scrub_valid, scrub_sel, scrub_data);
        end
        n_tests++;
        if ({mismatch2, multi_err2, c2_1, c2_2, c2_3, fault2, scrub_valid2, scrub_sel2, scrub_data2} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_cnt2: fault=%b sv=%b cnt=%0d/%0d/%0d, required all 0",
                     fault2, scrub_valid2, c2_1, c2_2, c2_3);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_all_match();
        logic [2:0] em;
        for (int k = 0; k < 10; k++) begin
            drive_sample(4'hA, 4'hA, 4'hA, 4'hA, 1'b0);
            em = q_mis.pop_front();
            n_tests++;
            if (mismatch !== em || scrub_valid !== 1'b0 || fault !== 3'b000) begin
                n_fail++;
                $display("FAIL all_match[%0d]: mis=%b sv=%b fault=%b, required mis=%b sv=0 fault=000",
                         k, mismatch, scrub_valid, fault, em);
            end
        end
        n_tests++;
        if (err_cnt_1 !== 8'(exp_cnt[0]) || err_cnt_2 !== 8'(exp_cnt[1]) || err_cnt_3 !== 8'(exp_cnt[2])) begin
            n_fail++;
            $display("FAIL all_match_cnt: got %0d/%0d/%0d required %0d/%0d/%0d",
                     err_cnt_1, err_cnt_2, err_cnt_3, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
        end
    endtask

    task automatic test_single_fault();
        logic [2:0] em;
        scrub_t     es;
        int         waited;
        scrub_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_sample(4'hA, 4'h5, 4'hA, 4'hA, 1'b0);
            em = q_mis.pop_front();
            n_tests++;
            if (mismatch !== em) begin
                n_fail++;
                $display("FAIL single_mis[%0d]: got %b required %b", k, mismatch, em);
            end
        end
        n_tests++;
        if (err_cnt_2 !== 8'(exp_cnt[1]) || fault !== 3'b010 || scrub_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_enter_faulty: cnt2=%0d fault=%b sv=%b, required cnt2=%0d fault=010 sv=0",
                     err_cnt_2, fault, scrub_valid, exp_cnt[1]);
        end
        q_scrub.push_back('{sel: 2'd2, data: 4'hA});
        waited = 0;
        while (scrub_valid !== 1'b1 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        es = q_scrub[0];
        n_tests++;
        if (scrub_valid !== 1'b1 || waited != 1 || scrub_sel !== es.sel || scrub_data !== es.data) begin
            n_fail++;
            $display("FAIL single_request: sv=%b after %0d cycles sel=%0d data=%h, required sv=1 after 1 sel=%0d data=%h",
                     scrub_valid, waited, scrub_sel, scrub_data, es.sel, es.data);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (scrub_valid !== 1'b1 || scrub_sel !== es.sel || scrub_data !== es.data || fault !== 3'b010) begin
                n_fail++;
                $display("FAIL single_hold[%0d]: sv=%b sel=%0d data=%h fault=%b, required sv=1 sel=%0d data=%h fault=010",
                         k, scrub_valid, scrub_sel, scrub_data, fault, es.sel, es.data);
            end
        end
        scrub_ready = 1'b1;
        @(posedge clk);
        #1;
        scrub_ready = 1'b0;
        void'(q_scrub.pop_front());
        n_tests++;
        if (scrub_valid !== 1'b0 || scrub_sel !== 2'd0 || fault !== 3'b000) begin
            n_fail++;
            $display("FAIL single_after_hs: sv=%b sel=%0d fault=%b, required sv=0 sel=0 fault=000",
                     scrub_valid, scrub_sel, fault);
        end
    endtask

    task automatic test_no_fault();
        logic [3:0] pat [5];
        logic [2:0] em;
        pat = '{4'h5, 4'h5, 4'hA, 4'h5, 4'h5};
        for (int k = 0; k < 5; k++) begin
            drive_sample(pat[k], 4'hA, 4'hA, 4'hA, 1'b0);
            em = q_mis.pop_front();
            n_tests++;
            if (mismatch !== em || fault !== 3'b000) begin
                n_fail++;
                $display("FAIL no_fault[%0d]: mis=%b fault=%b, required mis=%b fault=000", k, mismatch, fault, em);
            end
        end
        n_tests++;
        if (err_cnt_1 !== 8'(exp_cnt[0]) || exp_cnt[0] != 4) begin
            n_fail++;
            $display("FAIL no_fault_cnt1: got %0d required 4", err_cnt_1);
        end
        drive_sample(4'hA, 4'hA, 4'hA, 4'hA, 1'b0);
        void'(q_mis.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [2:0] em;
        scrub_t     es;
        scrub_ready = 1'b1;
        drive_sample(4'h5, 4'hA, 4'h5, 4'hA, 1'b0);
        drive_sample(4'h5, 4'hA, 4'h5, 4'hA, 1'b0);
        drive_sample(4'h5, 4'hC, 4'h5, 4'hC, 1'b0);
        for (int k = 0; k < 3; k++) begin
            em = q_mis.pop_front();
            n_tests++;
            if (em !== 3'b101) begin
                n_fail++;
                $display("FAIL b2b_queue[%0d]: queued %b required 101", k, em);
            end
        end
        n_tests++;
        if (mismatch !== 3'b101 || fault !== 3'b101 || scrub_valid !== 1'b0 || multi_err !== exp_multi) begin
            n_fail++;
            $display("FAIL b2b_faulty: mis=%b fault=%b sv=%b multi=%b, required 101/101/0/%b",
                     mismatch, fault, scrub_valid, multi_err, exp_multi);
        end
        q_scrub.push_back('{sel: 2'd1, data: 4'hC});
        q_scrub.push_back('{sel: 2'd3, data: 4'hC});
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            es = q_scrub.pop_front();
            n_tests++;
            if (scrub_valid !== 1'b1 || scrub_sel !== es.sel || scrub_data !== es.data) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: sv=%b sel=%0d data=%h, required sv=1 sel=%0d data=%h",
                         k, scrub_valid, scrub_sel, scrub_data, es.sel, es.data);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (scrub_valid !== 1'b0 || scrub_sel !== 2'd0 || fault !== ((k == 0) ? 3'b100 : 3'b000)) begin
                n_fail++;
                $display("FAIL b2b_idle[%0d]: sv=%b sel=%0d fault=%b, required sv=0 sel=0 fault=%b",
                         k, scrub_valid, scrub_sel, fault, (k == 0) ? 3'b100 : 3'b000);
            end
        end
        scrub_ready = 1'b0;
    endtask

    task automatic test_multi_err();
        logic [2:0] em;
        do_clear();
        n_tests++;
        if (multi_err !== exp_multi || err_cnt_1 !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_idle: multi=%b cnt1=%0d, required multi=0 cnt1=0", multi_err, err_cnt_1);
        end
        for (int k = 0; k < 2; k++) begin
            drive_sample(4'h1, 4'h2, 4'h0, 4'h0, (k == 1));
            em = q_mis.pop_front();
            n_tests++;
            if (mismatch !== em || multi_err !== exp_multi ||
                err_cnt_1 !== 8'(exp_cnt[0]) || err_cnt_2 !== 8'(exp_cnt[1])) begin
                n_fail++;
                $display("FAIL multi[%0d]: mis=%b multi=%b cnt=%0d/%0d, required %b/%b/%0d/%0d",
                         k, mismatch, multi_err, err_cnt_1, err_cnt_2, em, exp_multi, exp_cnt[0], exp_cnt[1]);
            end
        end
        drive_sample(4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        void'(q_mis.pop_front());
        do_clear();
        n_tests++;
        if (multi_err !== exp_multi) begin
            n_fail++;
            $display("FAIL multi_cleared: got %b required %b", multi_err, exp_multi);
        end
    endtask

    task automatic test_saturate_reset();
        logic [2:0] em;
        do_clear();
        for (int k = 0; k < 5; k++) begin
            drive_sample(4'hA, 4'hA, 4'h5, 4'hA, 1'b0);
            em = q_mis.pop_front();
            n_tests++;
            if (mismatch !== em || err_cnt_3 !== 8'(exp_cnt[2]) || c2_3 !== 2'(exp_cnt2[2])) begin
                n_fail++;
                $display("FAIL sat[%0d]: mis=%b cnt3=%0d cnt3_w2=%0d, required %b/%0d/%0d",
                         k, mismatch, err_cnt_3, c2_3, em, exp_cnt[2], exp_cnt2[2]);
            end
        end
        n_tests++;
        if (c2_3 !== 2'd3 || scrub_valid !== 1'b1 || scrub_sel !== 2'd3 || scrub_data !== 4'hA ||
            scrub_valid2 !== 1'b1 || scrub_sel2 !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_pending: cnt3_w2=%0d sv=%b sel=%0d data=%h sv2=%b sel2=%0d, required 3/1/3/a/1/3",
                     c2_3, scrub_valid, scrub_sel, scrub_data, scrub_valid2, scrub_sel2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({mismatch, multi_err, err_cnt_1, err_cnt_2, err_cnt_3, fault, scrub_valid, scrub_sel, scrub_data} !== '0 ||
            {mismatch2, multi_err2, c2_1, c2_2, c2_3, fault2, scrub_valid2, scrub_sel2, scrub_data2} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: sv=%b sel=%0d fault=%b cnt3=%0d sv2=%b cnt3_w2=%0d, required all 0",
                     scrub_valid, scrub_sel, fault, err_cnt_3, scrub_valid2, c2_3);
        end
        for (int i = 0; i < 3; i++) begin
            exp_cnt[i]  = 0;
            exp_cnt2[i] = 0;
        end
        exp_multi = 1'b0;
        q_mis.delete();
        q_scrub.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        data_1 = '0; data_2 = '0; data_3 = '0; voted_data = '0;
        err_clr = 1'b0;
        scrub_ready = 1'b0;
        exp_multi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_cnt[i]  = 0;
            exp_cnt2[i] = 0;
        end
        #1;
        test_reset();
        test_all_match();
        test_single_fault();
        test_no_fault();
        test_back_to_back();
        test_multi_err();
        test_saturate_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
